pwm_peripheral: RTL and testbench
=================================

# pwm_peripheral

Downstream consumer of the SPI register bank: takes the five 8-bit control registers written over SPI and drives 16 output pins. Each pin is off, statically on, or driven by a shared 8-bit PWM waveform at roughly 3 kHz for a 10 MHz clock. The duty value is double-buffered so that updates never produce a runt or glitched period.

## Interface
- CLK_DIV, default 13: clock cycles per PWM counter step. Must be ≥ 2. Period = CLK_DIV × 256 clk.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en_reg_out_7_0  input  8  output enables for pins 7..0.
- en_reg_out_15_8  input  8  output enables for pins 15..8.
- en_reg_pwm_7_0  input  8  PWM mode select for pins 7..0.
- en_reg_pwm_15_8  input  8  PWM mode select for pins 15..8.
- pwm_duty_cycle  input  8  requested duty; on-time is N/256, and 0xFF means 100%.
- out  output  16  pin drive; bit i corresponds to pin i.
- period_start  output  1  one-cycle pulse at the start of each PWM period.

All inputs are synchronous to clk. They come from the SPI register bank and need no CDC.

## Operation
- **Prescaler.** div_cnt counts 0..CLK_DIV-1 and then wraps to 0. tick = (div_cnt == CLK_DIV-1).
- **PWM counter.** pwm_cnt is 8 bits and increments on tick, wrapping from 255 to 0. It does not move between ticks.
- **Wrap event.** wrap = tick && pwm_cnt == 255.
- **Duty shadow.** On wrap, duty_act <= pwm_duty_cycle. At all other times duty_act holds its value.
- **PWM level.**
  - pwm_lvl = 1 if duty_act == 0xFF.
  - Otherwise pwm_lvl = (pwm_cnt < duty_act).
  - Result: duty 0 is always low, duty 0xFF is always high, and duty N is high for N counter steps per period.
- **Per-pin select.** For each i in 0..15, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}:
  - en_out[i] = 0 → out[i] = 0.
  - en_out[i] = 1 and en_pwm[i] = 0 → out[i] = 1.
  - en_out[i] = 1 and en_pwm[i] = 1 → out[i] = pwm_lvl.
  - en_pwm alone never drives a pin.
- **Registered outputs.** out and period_start are registered. period_start is high for the one cycle after wrap, which is the cycle in which pwm_cnt == 0 first appears.

## Timing
- **Reset values.** out = 0, period_start = 0, div_cnt = 0, pwm_cnt = 0, duty_act = 0.
- **Reset mid-period.** All state clears immediately. After release, the first period is a full CLK_DIV × 256 cycles with duty 0. The current pwm_duty_cycle takes effect at the first wrap.
- **Enable latency.** A change to en_out or en_pwm appears on out one clk after the input changes.
- **Duty latency.** A change to pwm_duty_cycle takes effect from the next period start only. Writes in mid-period are not visible until the wrap.
- **Duty changed on the wrap cycle.** If pwm_duty_cycle changes in the same cycle as wrap, the new value is captured.
- **High time per period.**
  - Duty N < 255: exactly N × CLK_DIV clk.
  - Duty 255: high for all CLK_DIV × 256 clk.
- **Rising edges.** In PWM mode, the rising edge on out, for duty ≥ 1, coincides with period_start.
- **period_start spacing.** Exactly CLK_DIV × 256 clk between pulses.
- **Pin-to-pin skew.** No skew between PWM pins, because they share pwm_lvl.

## Structure
- **Shared package pwm_pkg.** Contains:
  - PWM_RES = 8.
  - PWM_MAX = 8'hFF.
  - DEFAULT_CLK_DIV = 13.
  - A 16-bit pin_vec_t typedef.
- **Sub-module pwm_tick_gen.** Contains the prescaler and PWM counter. Parameter CLK_DIV; outputs tick, wrap, pwm_cnt.
- **Top level.** Holds duty_act, the compare, the per-pin mux, and the output registers.

## Test plan
- **Reset.** Hold rst_n = 0 with all enables 0xFF and duty 0x80 → out = 0x0000 and period_start = 0. Release → the first period has out = 0xFFFF on pins that are enabled but not in PWM mode, and out = 0 on PWM pins until the first wrap.
- **Static mode.**
  - Stimulus: en_out = 0x00FF, en_pwm = 0x0000.
  - Expected: out = 0x00FF one clk later, held indefinitely.
  - Stimulus: en_out = 0x0000, en_pwm = 0xFFFF.
  - Expected: out = 0x0000.
- **50% duty.**
  - Stimulus: CLK_DIV = 13, duty 0x80, en_out = en_pwm = 0x0001.
  - Expected: out[0] high for 1664 clk and low for 1664 clk.
  - Expected: period_start spacing is 3328 clk.
  - Expected: the rising edge of out[0] is aligned with period_start.
- **Extreme duty values.**
  - Duty 0x00 → out[0] never rises over 3 periods.
  - Duty 0xFF → out[0] never falls over 3 periods.
  - Duty 0x01 → out[0] is high for 13 clk per period.
- **Mid-period duty change.**
  - Stimulus: switch duty from 0x40 to 0xC0 at pwm_cnt = 0x20.
  - Expected: the current period keeps 832 clk high.
  - Expected: the next period is 2496 clk high, with no glitch at the change.
- **Mixed pins with async reset mid-period.**
  - Stimulus: en_out = 0xFFFF, en_pwm = 0xAAAA, duty 0x40.
  - Expected: even pins are constantly 1 and odd pins toggle together.
  - Stimulus: assert rst_n = 0 mid-period.
  - Expected: out = 0 in the same cycle, with no clock edge needed.
  - Expected after release: pwm_cnt restarts from 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripheral: resolution, full-scale duty,
// default prescaler and the pin vector type, plus the compare helper.
package pwm_pkg;

  localparam int              PWM_RES         = 8;
  localparam logic [7:0]      PWM_MAX         = 8'hFF;
  localparam int              DEFAULT_CLK_DIV = 13;

  typedef logic [15:0] pin_vec_t;

  // Waveform level for a counter position and an active duty value.
  // Full-scale duty is forced high so that 0xFF gives a true 100% output.
  function automatic logic pwm_level(input logic [PWM_RES-1:0] cnt,
                                     input logic [PWM_RES-1:0] duty);
    logic lvl;
    if (duty == PWM_MAX) begin
      lvl = 1'b1;
    end else begin
      lvl = (cnt < duty);
    end
    return lvl;
  endfunction

endpackage : pwm_pkg

// File: rtl/pwm_tick_gen.sv
// Prescaler and 8-bit PWM counter. The counter advances once every CLK_DIV
// clocks; wrap marks the last clock of a PWM period.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               tick,
  output logic               wrap,
  output logic [PWM_RES-1:0] pwm_cnt
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0]   div_cnt_r;
  logic [PWM_RES-1:0] pwm_cnt_r;
  logic               tick_s;

  assign tick_s  = (div_cnt_r == DIV_LAST);
  assign tick    = tick_s;
  assign wrap    = tick_s && (pwm_cnt_r == PWM_MAX);
  assign pwm_cnt = pwm_cnt_r;

  // Prescaler: count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // PWM counter: one step per prescaler tick, natural 8-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= '0;
    end else if (tick_s) begin
      pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

endmodule : pwm_tick_gen

// File: rtl/pwm_peripheral.sv
// PWM output stage: 16 pins, each off, statically on, or following a shared
// double-buffered PWM waveform. The output register is loaded from the
// next-state counter and duty so that out lines up with period_start and the
// high time is exactly duty x CLK_DIV clocks.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  logic               tick_s;
  logic               wrap_s;
  logic [PWM_RES-1:0] pwm_cnt_s;

  logic [PWM_RES-1:0] duty_act_r;
  logic [PWM_RES-1:0] duty_next_s;
  logic [PWM_RES-1:0] cnt_next_s;
  logic               pwm_lvl_next_s;
  pin_vec_t           en_out_s;
  pin_vec_t           en_pwm_s;
  pin_vec_t           out_next_s;
  pin_vec_t           out_r;
  logic               period_start_r;

  pwm_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick_s),
    .wrap    (wrap_s),
    .pwm_cnt (pwm_cnt_s)
  );

  assign en_out_s = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_s = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Next-state duty/counter and the per-pin mux feeding the output register.
  always_comb begin
    duty_next_s    = duty_act_r;
    cnt_next_s     = pwm_cnt_s;
    pwm_lvl_next_s = 1'b0;
    out_next_s     = '0;
    if (wrap_s) begin
      duty_next_s = pwm_duty_cycle;
    end else begin
      duty_next_s = duty_act_r;
    end
    if (tick_s) begin
      cnt_next_s = pwm_cnt_s + 8'd1;
    end else begin
      cnt_next_s = pwm_cnt_s;
    end
    pwm_lvl_next_s = pwm_level(cnt_next_s, duty_next_s);
    out_next_s     = en_out_s & (~en_pwm_s | {16{pwm_lvl_next_s}});
  end

  // Duty shadow: only reloaded on the period wrap, so no runt periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act_r <= '0;
    end else begin
      duty_act_r <= duty_next_s;
    end
  end

  // Registered pin drive and period-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r          <= '0;
      period_start_r <= 1'b0;
    end else begin
      out_r          <= out_next_s;
      period_start_r <= wrap_s;
    end
  end

  assign out          = out_r;
  assign period_start = period_start_r;

endmodule : pwm_peripheral

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral. The reference model derives the
// expected pin state from the number of clocks since reset release:
// counter = (n / CLK_DIV) mod 256, a new period every CLK_DIV*256 clocks,
// and the duty of each period is the input seen on that period's first edge.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int P       = CLK_DIV * 256;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out_v;
  logic [15:0] en_pwm_v;
  logic [7:0]  duty_v;
  logic [15:0] out_s;
  logic        ps_s;

  int          checks;
  int          failures;
  int          n;
  logic [7:0]  cur_duty;
  int          hi_acc;
  int          last_hi;
  int          rises;
  int          falls;
  int          misalign;
  int          last_ps_n;
  int          last_spacing;
  logic        prev0;

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_v[7:0]),
    .en_reg_out_15_8 (en_out_v[15:8]),
    .en_reg_pwm_7_0  (en_pwm_v[7:0]),
    .en_reg_pwm_15_8 (en_pwm_v[15:8]),
    .pwm_duty_cycle  (duty_v),
    .out             (out_s),
    .period_start    (ps_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n            = 0;
    cur_duty     = 8'h00;
    hi_acc       = 0;
    last_hi      = 0;
    last_ps_n    = 0;
    last_spacing = 0;
    prev0        = 1'b0;
  endtask

  // One clock: advance the model, compare both outputs, update statistics.
  task automatic step();
    logic [15:0] eo_b;
    logic [15:0] ep_b;
    logic [7:0]  du_b;
    int          cnt;
    logic        lvl;
    logic [15:0] exp_out;
    logic        exp_ps;
    eo_b = en_out_v;
    ep_b = en_pwm_v;
    du_b = duty_v;
    @(posedge clk);
    n = n + 1;
    exp_ps = ((n % P) == 0);
    if (exp_ps) cur_duty = du_b;
    cnt     = (n / CLK_DIV) % 256;
    lvl     = (cur_duty == 8'hFF) || (cnt < int'(cur_duty));
    exp_out = eo_b & (~ep_b | {16{lvl}});
    #1;
    chk("out", 32'(out_s), 32'(exp_out));
    chk("period_start", 32'(ps_s), 32'(exp_ps));
    if (ps_s) begin
      last_spacing = n - last_ps_n;
      last_ps_n    = n;
    end
    if (exp_ps) begin
      last_hi = hi_acc;
      hi_acc  = 0;
    end
    hi_acc = hi_acc + int'(out_s[0]);
    if (out_s[0] && !prev0) begin
      rises++;
      if (!ps_s) misalign++;
    end
    if (!out_s[0] && prev0) falls++;
    prev0 = out_s[0];
  endtask

  task automatic run_periods(input int k);
    int seen;
    int guard;
    seen  = 0;
    guard = 0;
    while (seen < k && guard < k * P + 16) begin
      step();
      guard++;
      if ((n % P) == 0) seen++;
    end
    chk("period_bound", 32'(seen), 32'(k));
  endtask

  initial begin
    int guard;
    logic [15:0] odd;
    checks   = 0;
    failures = 0;
    model_reset();
    rises    = 0;
    falls    = 0;
    misalign = 0;

    // Reset held with everything enabled.
    rst_n    = 1'b0;
    en_out_v = 16'hFFFF;
    en_pwm_v = 16'h00FF;
    duty_v   = 8'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_s), 32'h0000);
    chk("rst_ps", 32'(ps_s), 32'h0);

    // Release: first period has duty 0 on PWM pins.
    rst_n = 1'b1;
    model_reset();
    repeat (5) step();
    chk("first_period_out", 32'(out_s), 32'hFF00);
    run_periods(1);

    // Static mode.
    en_out_v = 16'h00FF;
    en_pwm_v = 16'h0000;
    step();
    chk("static_on", 32'(out_s), 32'h00FF);
    repeat (20) step();
    chk("static_hold", 32'(out_s), 32'h00FF);
    en_out_v = 16'h0000;
    en_pwm_v = 16'hFFFF;
    step();
    chk("pwm_only_off", 32'(out_s), 32'h0000);
    repeat (20) step();

    // 50% duty on pin 0.
    en_out_v = 16'h0001;
    en_pwm_v = 16'h0001;
    duty_v   = 8'h80;
    run_periods(1);
    rises    = 0;
    misalign = 0;
    run_periods(1);
    chk("hi_50", 32'(last_hi), 32'd1664);
    chk("spacing_50", 32'(last_spacing), 32'(P));
    chk("rise_aligned", 32'(misalign), 32'd0);
    chk("rises_50", 32'(rises), 32'd1);

    // Duty 0: never rises.
    duty_v = 8'h00;
    run_periods(1);
    rises = 0;
    run_periods(3);
    chk("duty0_rises", 32'(rises), 32'd0);

    // Duty 0xFF: never falls.
    duty_v = 8'hFF;
    run_periods(1);
    falls = 0;
    run_periods(3);
    chk("dutyff_falls", 32'(falls), 32'd0);
    chk("dutyff_hi", 32'(last_hi), 32'(P));

    // Duty 1: one counter step high.
    duty_v = 8'h01;
    run_periods(2);
    chk("duty1_hi", 32'(last_hi), 32'd13);

    // Mid-period change 0x40 -> 0xC0 at counter 0x20.
    duty_v = 8'h40;
    run_periods(1);
    guard = 0;
    while (((n / CLK_DIV) % 256) != 32 && guard < P) begin
      step();
      guard++;
    end
    chk("reach_cnt20", 32'((n / CLK_DIV) % 256), 32'd32);
    duty_v = 8'hC0;
    run_periods(1);
    chk("mid_keep_hi", 32'(last_hi), 32'd832);
    falls = 0;
    run_periods(1);
    chk("mid_new_hi", 32'(last_hi), 32'd2496);
    chk("mid_one_fall", 32'(falls), 32'd1);

    // Mixed pins, then random enables/duty against the model.
    en_out_v = 16'hFFFF;
    en_pwm_v = 16'hAAAA;
    duty_v   = 8'h40;
    repeat (300) step();
    chk("even_pins_on", 32'(out_s & 16'h5555), 32'h5555);
    odd = out_s & 16'hAAAA;
    chk("odd_together", 32'((odd == 16'h0000) || (odd == 16'hAAAA)), 32'h1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        en_out_v = 16'($urandom);
        en_pwm_v = 16'($urandom);
        duty_v   = 8'($urandom);
      end
      step();
    end
    en_out_v = 16'hFFFF;
    en_pwm_v = 16'hAAAA;
    duty_v   = 8'h40;
    repeat (5) step();

    // Asynchronous reset mid-period: out clears without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", 32'(out_s), 32'h0000);
    chk("async_ps", 32'(ps_s), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    step();
    step();
    chk("post_rst_out", 32'(out_s), 32'h5555);
    run_periods(1);
    chk("post_rst_spacing", 32'(last_spacing), 32'(P));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pwm_peripheral
